ysyx_22040895_redirect_ctrl: RTL
================================

Name: ysyx_22040895_redirect_ctrl

Overview:
Sequences control-flow redirects for the pipelined core. Consumes the EX-stage branch-compare result (taken flag and target), unconditional-jump and trap requests. Squashes younger IF/ID and ID/EX contents and holds a redirect PC until the IFU accepts it. Tracks outstanding fetch requests so that stale responses from the old path are killed.

Parameters:
XLEN, 64, width of PC/target buses.
MAX_OUTSTANDING, 2, maximum in-flight IFU fetch requests; counters are $clog2(MAX_OUTSTANDING+1) bits wide.

Ports:
clk_i_rdc  input  1  core clock
rst_n_i_rdc  input  1  asynchronous active-low reset
ex_valid_i_rdc  input  1  EX stage holds a valid instruction
bcuop_i_rdc  input  3  branch op of EX instruction; 3'b000 = not a branch
jump_branch_i_rdc  input  1  branch-compare taken flag
dnpc_i_rdc  input  XLEN  branch target
jal_i_rdc  input  1  EX holds jal/jalr
jtarget_i_rdc  input  XLEN  jump target
trap_i_rdc  input  1  trap/mret redirect request, independent of ex_valid
trap_pc_i_rdc  input  XLEN  trap/mret target
ifu_ready_i_rdc  input  1  IFU accepts redirect this cycle
fetch_issue_i_rdc  input  1  IFU issued one fetch request
fetch_resp_i_rdc  input  1  one fetch response returned
redirect_valid_o_rdc  output  1  redirect pending to IFU
redirect_pc_o_rdc  output  XLEN  redirect target
flush_ifid_o_rdc  output  1  kill IF/ID register contents
flush_idex_o_rdc  output  1  kill ID/EX register contents
resp_kill_o_rdc  output  1  current fetch response is wrong-path; discard

Behaviour:
- Reset, asynchronous and active-low: state=IDLE; out_cnt=0; drop_cnt=0; redirect_pc=0. All outputs are 0 immediately on reset assertion, including mid-redirect. Pending work is abandoned.
- Request decode (combinational):
  - br_req = ex_valid & (bcuop!=0) & jump_branch
  - j_req = ex_valid & jal
  - req = trap | j_req | br_req
- Target priority: trap_pc > jtarget > dnpc.
- States:
  - IDLE: on req, assert flush_ifid and flush_idex in the same cycle. Register the target. Go to REDIR. redirect_valid rises on the next cycle, giving 1-cycle latency.
  - REDIR: redirect_valid=1. redirect_pc is held stable. flush_ifid=1 every cycle. Branch/jump requests are ignored. A trap overwrites redirect_pc and pulses flush_idex, staying in REDIR. All fetch responses are killed. On ifu_ready, the redirect is accepted:
    - drop_cnt <= out_cnt minus the response returned this cycle.
    - If that value is 0, go to IDLE; otherwise go to DRAIN.
    - If a trap arrives in the accept cycle, it wins: re-capture the target and stay in REDIR.
  - DRAIN: each fetch_resp with drop_cnt>0 asserts resp_kill and decrements drop_cnt. Go to IDLE when drop_cnt reaches 0. A req in DRAIN behaves as in IDLE (flush, go to REDIR). The new accept recomputes drop_cnt from out_cnt.
- out_cnt: +1 on issue, -1 on resp, unchanged on both. It saturates at 0 and at MAX_OUTSTANDING. The IFU guarantees it never issues when full or responds when empty.
- Fetches issued after an accept belong to the new path. They are counted in out_cnt but not in drop_cnt, so responses are ordered oldest-first.
- A not-taken branch (jump_branch=0), or bcuop=0 with jump_branch=1, produces no action.

Optional Feature:
YSYX_22040895_BR_STAT_EN
- Defined: adds three 32-bit outputs, reset to 0 and wrapping on overflow:
  - br_total_o_rdc increments on ex_valid & bcuop!=0 in IDLE/DRAIN.
  - br_taken_o_rdc increments on br_req.
  - redir_wait_o_rdc increments each REDIR cycle with ifu_ready=0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. Taken beq: ex_valid=1, bcuop=001, jump_branch=1, dnpc=0x80000010, out_cnt=0, ifu_ready=1.
   - Cycle N: flush_ifid=flush_idex=1.
   - N+1: redirect_valid=1, pc=0x80000010.
   - N+2: IDLE, all outputs 0.
2. Not-taken bne: bcuop=110, jump_branch=0 -> no flush and no redirect for 5 cycles.
3. IFU back-pressure: taken branch with ifu_ready=0 for 3 cycles -> redirect_valid high 4 cycles, pc constant, flush_ifid high throughout.
4. Stale drain: two fetch issues before the branch, accept with no resp that cycle -> next two resps have resp_kill=1. A third resp issued after accept has resp_kill=0, and the FSM is back in IDLE.
5. Priority: trap_pc=0x80000100 and a taken branch to 0x80000010 in the same cycle -> redirect_pc=0x80000100. A trap to 0x80000200 during REDIR replaces the pc before accept.
6. Reset in REDIR: rst_n low mid-redirect -> redirect_valid, flushes and resp_kill are 0 asynchronously. After release, state is IDLE with out_cnt=0.

Source files
------------

// File: rtl/ysyx_22040895_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22040895_redirect_ctrl
//
// Sequences control-flow redirects. Taken EX-stage branches, jal/jalr and
// trap/mret requests flush the younger pipeline registers. A redirect PC is
// then held until the IFU accepts it. Fetch requests still in flight when the
// redirect is accepted come from the old path, so their responses are killed.
//
// Ports:
//   clk_i_rdc, rst_n_i_rdc      clock, asynchronous active-low reset
//   ex_valid_i_rdc              EX holds a valid instruction
//   bcuop_i_rdc                 EX branch op (0 = not a branch)
//   jump_branch_i_rdc           branch-compare taken flag
//   dnpc_i_rdc                  branch target
//   jal_i_rdc, jtarget_i_rdc    jal/jalr in EX and its target
//   trap_i_rdc, trap_pc_i_rdc   trap/mret redirect request and target
//   ifu_ready_i_rdc             IFU accepts the pending redirect
//   fetch_issue_i_rdc           IFU issued one fetch request
//   fetch_resp_i_rdc            one fetch response returned
//   redirect_valid_o_rdc        redirect pending to the IFU
//   redirect_pc_o_rdc           redirect target (0 when no redirect pending)
//   flush_ifid_o_rdc            kill IF/ID contents
//   flush_idex_o_rdc            kill ID/EX contents
//   resp_kill_o_rdc             current fetch response is wrong-path
//
// Optional feature, enabled by defining YSYX_22040895_BR_STAT_EN:
//   br_total_o_rdc, br_taken_o_rdc, redir_wait_o_rdc  32-bit wrapping counters
// ---------------------------------------------------------------------------
module ysyx_22040895_redirect_ctrl #(
    parameter int XLEN            = 64,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk_i_rdc,
    input  logic            rst_n_i_rdc,
    input  logic            ex_valid_i_rdc,
    input  logic [2:0]      bcuop_i_rdc,
    input  logic            jump_branch_i_rdc,
    input  logic [XLEN-1:0] dnpc_i_rdc,
    input  logic            jal_i_rdc,
    input  logic [XLEN-1:0] jtarget_i_rdc,
    input  logic            trap_i_rdc,
    input  logic [XLEN-1:0] trap_pc_i_rdc,
    input  logic            ifu_ready_i_rdc,
    input  logic            fetch_issue_i_rdc,
    input  logic            fetch_resp_i_rdc,
    output logic            redirect_valid_o_rdc,
    output logic [XLEN-1:0] redirect_pc_o_rdc,
    output logic            flush_ifid_o_rdc,
    output logic            flush_idex_o_rdc,
`ifdef YSYX_22040895_BR_STAT_EN
    output logic [31:0]     br_total_o_rdc,
    output logic [31:0]     br_taken_o_rdc,
    output logic [31:0]     redir_wait_o_rdc,
`endif
    output logic            resp_kill_o_rdc
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     out_cnt;
    logic [CW-1:0]     drop_cnt, drop_nxt;
    logic [XLEN-1:0]   redirect_pc, pc_nxt;

    logic              br_req, j_req, req;
    logic [XLEN-1:0]   tgt;
    logic [CW-1:0]     out_after_resp;

    logic              redirect_valid, flush_ifid, flush_idex, resp_kill;

    assign br_req = ex_valid_i_rdc & (bcuop_i_rdc != 3'b000) & jump_branch_i_rdc;
    assign j_req  = ex_valid_i_rdc & jal_i_rdc;
    assign req    = trap_i_rdc | j_req | br_req;
    assign tgt    = trap_i_rdc ? trap_pc_i_rdc : (j_req ? jtarget_i_rdc : dnpc_i_rdc);

    // Requests still outstanding once this cycle's response (if any) is retired;
    // these are exactly the old-path fetches left to drop after an accept.
    assign out_after_resp = out_cnt - CW'(fetch_resp_i_rdc);

    always_comb begin
        state_nxt      = state;
        pc_nxt         = redirect_pc;
        drop_nxt       = drop_cnt;
        redirect_valid = 1'b0;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;
        resp_kill      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    pc_nxt     = tgt;
                    state_nxt  = REDIR;
                end
            end
            REDIR: begin
                redirect_valid = 1'b1;
                flush_ifid     = 1'b1;
                resp_kill      = fetch_resp_i_rdc;
                // A trap outranks everything, including an accept this cycle.
                if (trap_i_rdc) begin
                    flush_idex = 1'b1;
                    pc_nxt     = trap_pc_i_rdc;
                end else if (ifu_ready_i_rdc) begin
                    drop_nxt  = out_after_resp;
                    state_nxt = (out_after_resp == '0) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (fetch_resp_i_rdc && drop_cnt != '0) begin
                    resp_kill = 1'b1;
                    drop_nxt  = drop_cnt - CW'(1);
                end
                if (req) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    pc_nxt     = tgt;
                    state_nxt  = REDIR;
                end else if (drop_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i_rdc or negedge rst_n_i_rdc) begin
        if (!rst_n_i_rdc) begin
            state       <= IDLE;
            drop_cnt    <= '0;
            redirect_pc <= '0;
        end else begin
            state       <= state_nxt;
            drop_cnt    <= drop_nxt;
            redirect_pc <= pc_nxt;
        end
    end

    // Outstanding fetch counter; simultaneous issue+resp leaves it unchanged.
    always_ff @(posedge clk_i_rdc or negedge rst_n_i_rdc) begin
        if (!rst_n_i_rdc) begin
            out_cnt <= '0;
        end else if (fetch_issue_i_rdc && !fetch_resp_i_rdc &&
                     out_cnt != CW'(MAX_OUTSTANDING)) begin
            out_cnt <= out_cnt + CW'(1);
        end else if (fetch_resp_i_rdc && !fetch_issue_i_rdc && out_cnt != '0) begin
            out_cnt <= out_cnt - CW'(1);
        end
    end

    // Some outputs are combinational on live inputs; gating with reset keeps
    // every output at 0 for as long as reset is asserted.
    assign redirect_valid_o_rdc = redirect_valid & rst_n_i_rdc;
    assign redirect_pc_o_rdc    = redirect_valid_o_rdc ? redirect_pc : '0;
    assign flush_ifid_o_rdc     = flush_ifid & rst_n_i_rdc;
    assign flush_idex_o_rdc     = flush_idex & rst_n_i_rdc;
    assign resp_kill_o_rdc      = resp_kill & rst_n_i_rdc;

`ifdef YSYX_22040895_BR_STAT_EN
    always_ff @(posedge clk_i_rdc or negedge rst_n_i_rdc) begin
        if (!rst_n_i_rdc) begin
            br_total_o_rdc   <= '0;
            br_taken_o_rdc   <= '0;
            redir_wait_o_rdc <= '0;
        end else begin
            if (ex_valid_i_rdc && bcuop_i_rdc != 3'b000 && state != REDIR)
                br_total_o_rdc <= br_total_o_rdc + 32'd1;
            if (br_req)
                br_taken_o_rdc <= br_taken_o_rdc + 32'd1;
            if (state == REDIR && !ifu_ready_i_rdc)
                redir_wait_o_rdc <= redir_wait_o_rdc + 32'd1;
        end
    end
`endif

endmodule
